fwd_bypass_net: RTL and testbench

Parametrised result-forwarding network and writeback pipeline for the multi-issue SPU processing unit. It generalises the fixed two-pipe even/odd forwarding chain into NPIPE issue pipes with DEPTH tagged result stages each, per-instruction result latency, youngest-wins operand bypass and hazard stall generation. It sits between the register-file read ports and the execution units, and it drives the register-file write ports.

---
 rtl/fwd_bypass_net.sv | 210 +++++++++++++++++++++
 tb/tb_fwd_bypass_net.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_bypass_net.sv
// -----------------------------------------------------------------------------
// fwd_bypass_net
//
// Result-forwarding network and writeback pipeline for an NPIPE-wide issue
// stage. Every pipe carries DEPTH tagged result stages (stage 1 .. DEPTH).
// An accepted instruction enters stage 1 and moves one stage per clock.
// The pipe never freezes. When the entry leaves stage lat, it captures the
// execution-unit result and becomes ready. It retires to the register file
// from stage DEPTH.
//
// Operand reads are matched against every live writing entry in all pipes.
// The youngest match wins: a lower stage wins first, and within one stage the
// higher pipe index wins. A ready winner forwards its data. A winner that is
// not yet ready is a hazard. A hazard on any issuing pipe raises stall, and
// stall blocks every new issue in that cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset; clears every stage entry
//   iss_valid  [NPIPE]               issue request per pipe
//   iss_wr     [NPIPE]               issuing instruction writes a register
//   iss_rt     [NPIPE*ADDR_W]        destination register address
//   iss_lat    [NPIPE*LAT_W]         result latency (0 or >=DEPTH -> DEPTH-1)
//   rd_addr    [NPIPE*NREAD*ADDR_W]  operand addresses of issuing instructions
//   rf_data    [NPIPE*NREAD*DATA_W]  register-file read data for rd_addr
//   res_data   [NPIPE*DATA_W]        execution result for the entry at stage lat
//   opnd_data  [NPIPE*NREAD*DATA_W]  resolved operands (combinational)
//   stall      operand hazard on an issuing pipe; no issue accepted
//   wb_en      [NPIPE]               register-file write enable (stage DEPTH)
//   wb_addr    [NPIPE*ADDR_W]        register-file write address
//   wb_data    [NPIPE*DATA_W]        register-file write data
// -----------------------------------------------------------------------------
module fwd_bypass_net #(
  parameter int NPIPE  = 2,
  parameter int DEPTH  = 7,
  parameter int NREAD  = 3,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7,
  parameter int LAT_W  = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NPIPE-1:0]              iss_valid,
  input  logic [NPIPE-1:0]              iss_wr,
  input  logic [NPIPE*ADDR_W-1:0]       iss_rt,
  input  logic [NPIPE*LAT_W-1:0]        iss_lat,
  input  logic [NPIPE*NREAD*ADDR_W-1:0] rd_addr,
  input  logic [NPIPE*NREAD*DATA_W-1:0] rf_data,
  input  logic [NPIPE*DATA_W-1:0]       res_data,
  output logic [NPIPE*NREAD*DATA_W-1:0] opnd_data,
  output logic                          stall,
  output logic [NPIPE-1:0]              wb_en,
  output logic [NPIPE*ADDR_W-1:0]       wb_addr,
  output logic [NPIPE*DATA_W-1:0]       wb_data
);

  localparam int NSLOT = NPIPE * NREAD;

  // One tagged result slot. rdy means data already holds the final result.
  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [ADDR_W-1:0] rt;
    logic [LAT_W-1:0]  lat;
    logic              rdy;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Index [p][k] holds stage number k+1 of pipe p.
  entry_t stage_q [NPIPE][DEPTH];
  entry_t stage_d [NPIPE][DEPTH];

  // Per read slot (p*NREAD + r): winning candidate, and whether it is ready.
  logic [NSLOT-1:0]  win_hit;
  logic [NSLOT-1:0]  win_rdy;
  logic [DATA_W-1:0] win_data [NSLOT];

  logic [NPIPE-1:0]  accept;

  // A latency of 0 has no meaning, and a latency of DEPTH or more would
  // capture too late to retire a ready entry. Both map to the longest
  // legal latency.
  function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
    if (lat == '0 || lat >= LAT_W'(DEPTH)) begin
      return LAT_W'(DEPTH - 1);
    end
    return lat;
  endfunction

  // ---------------------------------------------------------------------------
  // Operand lookup.
  // Scan from the oldest slot (stage DEPTH, pipe 0) to the youngest slot
  // (stage 1, pipe NPIPE-1). The last match overwrites earlier ones, so the
  // youngest match wins. Only stage registers are searched. Instructions
  // issued in the same bundle are therefore never visible to each other.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output is given a default before any
    // conditional update, so no path leaves it unassigned and no latch is
    // inferred.
    win_hit = '0;
    win_rdy = '0;
    for (int i = 0; i < NSLOT; i++) begin
      win_data[i] = '0;
    end

    for (int p = 0; p < NPIPE; p++) begin
      for (int r = 0; r < NREAD; r++) begin
        for (int s = DEPTH - 1; s >= 0; s--) begin
          for (int q = 0; q < NPIPE; q++) begin
            if (stage_q[q][s].valid && stage_q[q][s].wr &&
                stage_q[q][s].rt == rd_addr[(p*NREAD + r)*ADDR_W +: ADDR_W]) begin
              win_hit[p*NREAD + r]  = 1'b1;
              win_rdy[p*NREAD + r]  = stage_q[q][s].rdy;
              win_data[p*NREAD + r] = stage_q[q][s].data;
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand mux and stall.
  // A hazard counts toward stall only if its pipe is actually issuing.
  // ---------------------------------------------------------------------------
  always_comb begin
    opnd_data = rf_data;
    stall     = 1'b0;
    for (int p = 0; p < NPIPE; p++) begin
      for (int r = 0; r < NREAD; r++) begin
        if (win_hit[p*NREAD + r]) begin
          opnd_data[(p*NREAD + r)*DATA_W +: DATA_W] = win_data[p*NREAD + r];
        end
        if (iss_valid[p] && win_hit[p*NREAD + r] && !win_rdy[p*NREAD + r]) begin
          stall = 1'b1;
        end
      end
    end
  end

  assign accept = iss_valid & {NPIPE{~stall}};

  // ---------------------------------------------------------------------------
  // Next-state: fill stage 1, then shift every stage down unconditionally.
  // An entry at stage number k with lat == k captures res_data on the same
  // edge that moves it to stage k+1.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int p = 0; p < NPIPE; p++) begin
      stage_d[p][0] = '0;
      if (accept[p]) begin
        stage_d[p][0].valid = 1'b1;
        stage_d[p][0].wr    = iss_wr[p];
        stage_d[p][0].rt    = iss_rt[p*ADDR_W +: ADDR_W];
        stage_d[p][0].lat   = clamp_lat(iss_lat[p*LAT_W +: LAT_W]);
      end

      for (int k = 1; k < DEPTH; k++) begin
        stage_d[p][k] = stage_q[p][k-1];
        if (stage_q[p][k-1].valid && stage_q[p][k-1].lat == LAT_W'(k)) begin
          stage_d[p][k].data = res_data[p*DATA_W +: DATA_W];
          stage_d[p][k].rdy  = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage registers.
  // ---------------------------------------------------------------------------
  // NOTE: state uses non-blocking assignments, so all stages sample the
  // pre-edge values and shift together. The data fields are reset along with
  // the control bits, so that writeback outputs are zero during and after
  // reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NPIPE; p++) begin
        for (int k = 0; k < DEPTH; k++) begin
          stage_q[p][k] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < NPIPE; p++) begin
        for (int k = 0; k < DEPTH; k++) begin
          stage_q[p][k] <= stage_d[p][k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Writeback from stage DEPTH.
  // These outputs depend only on registered state, so there is no
  // combinational path from iss_* to wb_*. When two pipes write the same
  // address, both enables are raised, and the register file resolves the
  // conflict.
  // ---------------------------------------------------------------------------
  always_comb begin
    wb_en   = '0;
    wb_addr = '0;
    wb_data = '0;
    for (int p = 0; p < NPIPE; p++) begin
      wb_en[p]                      = stage_q[p][DEPTH-1].valid & stage_q[p][DEPTH-1].wr;
      wb_addr[p*ADDR_W +: ADDR_W]   = stage_q[p][DEPTH-1].rt;
      wb_data[p*DATA_W +: DATA_W]   = stage_q[p][DEPTH-1].data;
    end
  end

endmodule

// File: tb/tb_fwd_bypass_net.sv
// -----------------------------------------------------------------------------
// tb_fwd_bypass_net
//
// Directed bench for fwd_bypass_net with the default parameters.
//
// The stimulus process drives one cycle at a time. For each cycle it pushes
// the expected responses into a scoreboard, tagged with the cycle in which
// they must appear. Expected values are hand-computed from the issue and
// latency timing.
//
// A separate monitor runs on each falling edge. It pops every expectation
// that is due in the current cycle and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_fwd_bypass_net;

  localparam int NPIPE  = 2;
  localparam int DEPTH  = 7;
  localparam int NREAD  = 3;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 7;
  localparam int LAT_W  = 3;

  logic                          clk = 1'b0;
  logic                          reset;
  logic [NPIPE-1:0]              iss_valid;
  logic [NPIPE-1:0]              iss_wr;
  logic [NPIPE*ADDR_W-1:0]       iss_rt;
  logic [NPIPE*LAT_W-1:0]        iss_lat;
  logic [NPIPE*NREAD*ADDR_W-1:0] rd_addr;
  logic [NPIPE*NREAD*DATA_W-1:0] rf_data;
  logic [NPIPE*DATA_W-1:0]       res_data;
  logic [NPIPE*NREAD*DATA_W-1:0] opnd_data;
  logic                          stall;
  logic [NPIPE-1:0]              wb_en;
  logic [NPIPE*ADDR_W-1:0]       wb_addr;
  logic [NPIPE*DATA_W-1:0]       wb_data;

  fwd_bypass_net #(
    .NPIPE (NPIPE),
    .DEPTH (DEPTH),
    .NREAD (NREAD),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .LAT_W (LAT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .iss_valid(iss_valid),
    .iss_wr   (iss_wr),
    .iss_rt   (iss_rt),
    .iss_lat  (iss_lat),
    .rd_addr  (rd_addr),
    .rf_data  (rf_data),
    .res_data (res_data),
    .opnd_data(opnd_data),
    .stall    (stall),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data)
  );

  always #5 clk = ~clk;

  // Cycle number. It changes on each rising edge and is stable in between.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {K_STALL, K_OPND, K_WB_EN, K_WB_ADDR, K_WB_DATA} kind_e;

  typedef struct {
    int                cyc;
    kind_e             kind;
    int                idx;
    logic [DATA_W-1:0] val;
    string             name;
  } exp_t;

  exp_t sb[$];
  exp_t keep_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic logic [DATA_W-1:0] pat(input logic [15:0] h);
    return {8{h}};
  endfunction

  function automatic logic [DATA_W-1:0] rf_val(input int idx);
    return {16{8'(8'hA0 + idx)}};
  endfunction

  function automatic logic [DATA_W-1:0] observe(input kind_e k, input int idx);
    case (k)
      K_STALL:   return DATA_W'(stall);
      K_OPND:    return opnd_data[idx*DATA_W +: DATA_W];
      K_WB_EN:   return DATA_W'(wb_en);
      K_WB_ADDR: return DATA_W'(wb_addr[idx*ADDR_W +: ADDR_W]);
      K_WB_DATA: return wb_data[idx*DATA_W +: DATA_W];
      default:   return '0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: compares every expectation that is due in the current cycle.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic [DATA_W-1:0] got;
    forever begin
      @(negedge clk);
      keep_q.delete();
      foreach (sb[i]) begin
        if (sb[i].cyc > cyc) begin
          keep_q.push_back(sb[i]);
        end else if (sb[i].cyc < cyc) begin
          n_vec++;
          n_miss++;
          $display("FAIL %s: due in cycle %0d, not compared (now %0d)",
                   sb[i].name, sb[i].cyc, cyc);
        end else begin
          n_vec++;
          got = observe(sb[i].kind, sb[i].idx);
          if (got !== sb[i].val) begin
            n_miss++;
            $display("FAIL %s: cycle %0d got %h want %h",
                     sb[i].name, cyc, got, sb[i].val);
          end
        end
      end
      sb = keep_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers.
  // ---------------------------------------------------------------------------
  task automatic clear_inputs();
    iss_valid = '0;
    iss_wr    = '0;
    iss_rt    = '0;
    iss_lat   = '0;
    rd_addr   = '0;
    res_data  = '0;
  endtask

  // Advance to the next cycle and drive idle inputs just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic issue(input int p, input logic wr, input int rt, input int lat);
    iss_valid[p]                = 1'b1;
    iss_wr[p]                   = wr;
    iss_rt[p*ADDR_W +: ADDR_W]  = ADDR_W'(rt);
    iss_lat[p*LAT_W +: LAT_W]   = LAT_W'(lat);
  endtask

  task automatic rd(input int p, input int r, input int a);
    rd_addr[(p*NREAD + r)*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic res(input int p, input logic [DATA_W-1:0] v);
    res_data[p*DATA_W +: DATA_W] = v;
  endtask

  task automatic exp_push(input int dly, input kind_e k, input int idx,
                          input logic [DATA_W-1:0] v, input string name);
    exp_t e;
    e.cyc  = cyc + dly;
    e.kind = k;
    e.idx  = idx;
    e.val  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic exp_opnd(input int dly, input int p, input int r,
                          input logic [DATA_W-1:0] v, input string name);
    exp_push(dly, K_OPND, p*NREAD + r, v, name);
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios.
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    reset = 1'b0;
    clear_inputs();
    for (int i = 0; i < NPIPE*NREAD; i++) begin
      rf_data[i*DATA_W +: DATA_W] = rf_val(i);
    end

    // Reset state.
    @(posedge clk);
    #1;
    exp_push(0, K_STALL, 0, 0, "rst_stall");
    exp_push(0, K_WB_EN, 0, 0, "rst_wb_en");
    exp_push(0, K_WB_ADDR, 1, 0, "rst_wb_addr1");
    exp_push(0, K_WB_DATA, 0, 0, "rst_wb_data0");
    exp_opnd(0, 0, 0, rf_val(0), "rst_opnd00");
    exp_opnd(0, 1, 2, rf_val(5), "rst_opnd12");
    step();
    reset = 1'b1;

    // Reset mid-operation: five writes in flight, then one cycle of reset.
    for (int i = 0; i < 5; i++) begin
      step();
      issue(0, 1'b1, i + 1, 6);
    end
    step();
    reset = 1'b0;
    issue(0, 1'b0, 0, 1);
    issue(1, 1'b0, 0, 1);
    rd(0, 0, 3);
    rd(1, 2, 5);
    exp_push(0, K_STALL, 0, 0, "midrst_stall");
    exp_push(0, K_WB_EN, 0, 0, "midrst_wb_en");
    exp_opnd(0, 0, 0, rf_val(0), "midrst_opnd00");
    exp_opnd(0, 1, 2, rf_val(5), "midrst_opnd12");
    for (int k = 0; k < 7; k++) begin
      step();
      if (k == 0) reset = 1'b1;
      issue(0, 1'b0, 0, 1);
      issue(1, 1'b0, 0, 1);
      rd(0, 0, 3);
      rd(1, 2, 5);
      exp_push(0, K_STALL, 0, 0, "postrst_stall");
      exp_push(0, K_WB_EN, 0, 0, "postrst_wb_en");
      exp_opnd(0, 0, 0, rf_val(0), "postrst_opnd00");
      exp_opnd(0, 1, 2, rf_val(5), "postrst_opnd12");
    end
    idle(DEPTH);

    // Unfinished RAW: rt=4, L=2 on pipe0; dependent ra=4 from T+1.
    step();                                                   // T
    issue(0, 1'b1, 4, 2);
    exp_push(0, K_STALL, 0, 0, "raw_t0_stall");
    step();                                                   // T+1
    issue(0, 1'b0, 0, 1);
    rd(0, 0, 4);
    exp_push(0, K_STALL, 0, 1, "raw_t1_stall");
    step();                                                   // T+2
    issue(0, 1'b0, 0, 1);
    rd(0, 0, 4);
    res(0, pat(16'h1234));
    exp_push(0, K_STALL, 0, 1, "raw_t2_stall");
    step();                                                   // T+3
    issue(0, 1'b0, 0, 1);
    rd(0, 0, 4);
    exp_push(0, K_STALL, 0, 0, "raw_t3_stall");
    exp_opnd(0, 0, 0, pat(16'h1234), "raw_t3_opnd");
    exp_push(4, K_WB_EN, 0, 2'b01, "raw_wb_en");
    exp_push(4, K_WB_ADDR, 0, 4, "raw_wb_addr");
    exp_push(4, K_WB_DATA, 0, pat(16'h1234), "raw_wb_data");
    idle(DEPTH);

    // Cross-pipe: pipe1 writes rt=8, L=4; pipe0 reads rb.
    step();                                                   // T
    issue(1, 1'b1, 8, 4);
    idle(3);                                                  // T+3
    rd(1, 0, 8);
    exp_push(0, K_STALL, 0, 0, "xp_noissue_stall");
    step();                                                   // T+4
    res(1, pat(16'hAAAA));
    issue(0, 1'b0, 0, 1);
    rd(0, 1, 8);
    exp_push(0, K_STALL, 0, 1, "xp_t4_stall");
    step();                                                   // T+5
    issue(0, 1'b0, 0, 1);
    rd(0, 1, 8);
    exp_push(0, K_STALL, 0, 0, "xp_t5_stall");
    exp_opnd(0, 0, 1, pat(16'hAAAA), "xp_t5_opnd");
    step();                                                   // T+6
    issue(0, 1'b0, 0, 1);
    rd(0, 1, 9);
    exp_opnd(0, 0, 1, rf_val(1), "xp_miss_opnd");
    exp_push(1, K_WB_EN, 0, 2'b10, "xp_wb_en");
    exp_push(1, K_WB_ADDR, 1, 8, "xp_wb_addr");
    exp_push(1, K_WB_DATA, 1, pat(16'hAAAA), "xp_wb_data");
    idle(DEPTH);

    // Youngest wins: rt=12 written at T and at T+3, both L=1.
    step();                                                   // T
    issue(0, 1'b1, 12, 1);
    step();                                                   // T+1
    res(0, pat(16'h1111));
    step();                                                   // T+2
    issue(1, 1'b0, 0, 1);
    rd(1, 0, 12);
    exp_push(0, K_STALL, 0, 0, "yw_t2_stall");
    exp_opnd(0, 1, 0, pat(16'h1111), "yw_t2_opnd");
    step();                                                   // T+3
    issue(0, 1'b1, 12, 1);
    step();                                                   // T+4
    res(0, pat(16'h2222));
    issue(1, 1'b0, 0, 1);
    rd(1, 0, 12);
    exp_push(0, K_STALL, 0, 1, "yw_t4_stall");
    step();                                                   // T+5
    issue(1, 1'b0, 0, 1);
    rd(1, 0, 12);
    exp_push(0, K_STALL, 0, 0, "yw_t5_stall");
    exp_opnd(0, 1, 0, pat(16'h2222), "yw_t5_opnd");
    exp_push(2, K_WB_EN, 0, 2'b01, "yw_wb1_en");
    exp_push(2, K_WB_ADDR, 0, 12, "yw_wb1_addr");
    exp_push(2, K_WB_DATA, 0, pat(16'h1111), "yw_wb1_data");
    exp_push(5, K_WB_EN, 0, 2'b01, "yw_wb2_en");
    exp_push(5, K_WB_DATA, 0, pat(16'h2222), "yw_wb2_data");
    idle(DEPTH);

    // Same-stage tie: both pipes write rt=20 at T, L=2.
    step();                                                   // T
    issue(0, 1'b1, 20, 2);
    issue(1, 1'b1, 20, 2);
    rd(1, 1, 20);
    exp_push(0, K_STALL, 0, 0, "tie_bundle_stall");
    exp_opnd(0, 1, 1, rf_val(4), "tie_bundle_opnd");
    step();                                                   // T+1
    step();                                                   // T+2
    res(0, pat(16'h5555));
    res(1, pat(16'h6666));
    step();                                                   // T+3
    issue(0, 1'b0, 0, 1);
    rd(0, 0, 20);
    exp_push(0, K_STALL, 0, 0, "tie_t3_stall");
    exp_opnd(0, 0, 0, pat(16'h6666), "tie_t3_opnd");
    exp_push(4, K_WB_EN, 0, 2'b11, "tie_wb_en");
    exp_push(4, K_WB_ADDR, 0, 20, "tie_wb_addr0");
    exp_push(4, K_WB_ADDR, 1, 20, "tie_wb_addr1");
    exp_push(4, K_WB_DATA, 0, pat(16'h5555), "tie_wb_data0");
    exp_push(4, K_WB_DATA, 1, pat(16'h6666), "tie_wb_data1");
    idle(DEPTH);

    // No-write issue, and issue blocked by stall.
    step();                                                   // T
    issue(0, 1'b0, 30, 1);
    step();                                                   // T+1
    issue(1, 1'b0, 0, 1);
    rd(1, 0, 30);
    exp_push(0, K_STALL, 0, 0, "nowr_stall");
    exp_opnd(0, 1, 0, rf_val(3), "nowr_opnd");
    step();                                                   // T+2
    issue(0, 1'b1, 40, 3);
    step();                                                   // T+3
    issue(1, 1'b1, 41, 1);
    rd(1, 0, 40);
    exp_push(0, K_STALL, 0, 1, "gate_stall");
    step();                                                   // T+4
    issue(0, 1'b0, 0, 1);
    rd(0, 0, 41);
    exp_push(0, K_STALL, 0, 0, "gate_t4_stall");
    exp_opnd(0, 0, 0, rf_val(0), "gate_bubble_opnd");
    exp_push(3, K_WB_EN, 0, 2'b00, "nowr_wb_en");
    exp_push(5, K_WB_EN, 0, 2'b01, "gate_wb40_en");
    exp_push(5, K_WB_ADDR, 0, 40, "gate_wb40_addr");
    exp_push(5, K_WB_DATA, 0, pat(16'h4040), "gate_wb40_data");
    exp_push(6, K_WB_EN, 0, 2'b00, "gate_bubble_wb_en");
    step();                                                   // T+5
    res(0, pat(16'h4040));
    idle(DEPTH);

    // Latency clamp: lat=0 on pipe0 and lat=7 on pipe1 both behave as L=6.
    step();                                                   // T
    issue(0, 1'b1, 50, 0);
    issue(1, 1'b1, 51, 7);
    idle(5);                                                  // T+5
    step();                                                   // T+6
    res(0, pat(16'h7777));
    res(1, pat(16'h7878));
    issue(0, 1'b0, 0, 1);
    rd(0, 0, 50);
    exp_push(0, K_STALL, 0, 1, "clamp_t6_stall");
    step();                                                   // T+7
    issue(0, 1'b0, 0, 1);
    rd(0, 0, 50);
    rd(0, 1, 51);
    exp_push(0, K_STALL, 0, 0, "clamp_t7_stall");
    exp_opnd(0, 0, 0, pat(16'h7777), "clamp_opnd50");
    exp_opnd(0, 0, 1, pat(16'h7878), "clamp_opnd51");
    exp_push(0, K_WB_EN, 0, 2'b11, "clamp_wb_en");
    exp_push(0, K_WB_DATA, 0, pat(16'h7777), "clamp_wb_data0");
    exp_push(0, K_WB_DATA, 1, pat(16'h7878), "clamp_wb_data1");

    idle(DEPTH + 2);

    // Any expectation that is still queued was never reached.
    foreach (sb[i]) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: due in cycle %0d, still pending at end", sb[i].name, sb[i].cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
